// File: rtl/cpu_trace_unit.sv
`default_nettype none
// ============================================================================
// Module   : cpu_trace_unit
// Purpose  : Observation port for the pipelined CPU. Captures register
//            writebacks and data-memory stores into an event FIFO. A 3-beat
//            valid/ready serializer streams the FIFO out. Also keeps
//            saturating cycle/stall/flush/drop statistics counters.
// Ports    : clk_i, rst_i (async, active-high)
//            start_i                      - capture/count enable
//            stall_i, branch_i, flush_i   - hazard/flush activity
//            wb_en_i, wb_rd_i, wb_data_i  - register writeback
//            mem_wr_i, mem_addr_i, mem_data_i - data-memory store
//            trace_valid_o/ready_i/data_o/last_o - trace stream
//            cycle/stall/flush/drop_cnt_o - statistics counters
// Revision : 1.0 - initial release
// ============================================================================
module cpu_trace_unit #(
  parameter int FIFO_DEPTH = 8,
  parameter int STAMP_W    = 16,
  parameter int CNT_W      = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             branch_i,
  input  logic             flush_i,
  input  logic             wb_en_i,
  input  logic [4:0]       wb_rd_i,
  input  logic [31:0]      wb_data_i,
  input  logic             mem_wr_i,
  input  logic [31:0]      mem_addr_i,
  input  logic [31:0]      mem_data_i,
  output logic             trace_valid_o,
  input  logic             trace_ready_i,
  output logic [31:0]      trace_data_o,
  output logic             trace_last_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] drop_cnt_o
);

  localparam int         PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int         FILL_W   = PTR_W + 1;
  localparam logic [1:0] TYPE_REG = 2'b01;
  localparam logic [1:0] TYPE_MEM = 2'b10;

  typedef struct packed {
    logic [1:0]         typ;
    logic [31:0]        field;   // rd (zero-extended) or byte address
    logic [31:0]        data;
    logic [STAMP_W-1:0] stamp;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_B0   = 2'd1,
    S_B1   = 2'd2,
    S_B2   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  entry_t             fifo_q [FIFO_DEPTH];
  entry_t             fifo_d [FIFO_DEPTH];
  entry_t             head_q, head_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d, stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d, drop_cnt_q, drop_cnt_d;

  logic               reg_ev, mem_ev, head_take;
  logic [FILL_W-1:0]  free_slots;
  logic [1:0]         n_events, n_push, n_drop;
  entry_t             reg_entry, mem_entry, first_entry;
  logic [31:0]        beat0;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [1:0]       b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  // Event capture and push/drop arbitration. Space comes from the registered
  // fill level only, so a same-cycle pop never makes room for these pushes.
  always_comb begin
    reg_ev     = start_i & wb_en_i & (wb_rd_i != 5'd0);
    mem_ev     = start_i & mem_wr_i;
    reg_entry  = '{typ: TYPE_REG, field: {27'b0, wb_rd_i}, data: wb_data_i,
                   stamp: cycle_cnt_q[STAMP_W-1:0]};
    mem_entry  = '{typ: TYPE_MEM, field: mem_addr_i, data: mem_data_i,
                   stamp: cycle_cnt_q[STAMP_W-1:0]};
    first_entry = reg_ev ? reg_entry : mem_entry;
    free_slots = FILL_W'(FIFO_DEPTH) - count_q;
    n_events   = {1'b0, reg_ev} + {1'b0, mem_ev};
    if (free_slots >= FILL_W'(2)) begin
      n_push = n_events;
    end else if (free_slots == FILL_W'(1)) begin
      n_push = (n_events != 2'd0) ? 2'd1 : 2'd0;
    end else begin
      n_push = 2'd0;
    end
    n_drop = n_events - n_push;
  end

  // The head leaves the FIFO when the serializer is idle, or when the last
  // beat of the current record completes (back-to-back records).
  assign head_take = (count_q != '0) &&
                     ((state_q == S_IDLE) || ((state_q == S_B2) && trace_ready_i));

  always_comb begin
    fifo_d = fifo_q;
    if (n_push != 2'd0) fifo_d[wr_ptr_q] = first_entry;
    if (n_push == 2'd2) fifo_d[wr_ptr_q + PTR_W'(1)] = mem_entry;
    wr_ptr_d = wr_ptr_q + PTR_W'(n_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(head_take);
    count_d  = count_q + FILL_W'(n_push) - FILL_W'(head_take);
  end

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    drop_cnt_d  = sat_add(drop_cnt_q, n_drop);
    if (start_i) begin
      cycle_cnt_d = sat_add(cycle_cnt_q, 2'd1);
      stall_cnt_d = sat_add(stall_cnt_q, {1'b0, stall_i & ~branch_i});
      flush_cnt_d = sat_add(flush_cnt_q, {1'b0, flush_i});
    end
  end

  // Serializer next state.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    case (state_q)
      S_IDLE:  if (count_q != '0) state_d = S_B0;
      S_B0:    if (trace_ready_i) state_d = S_B1;
      S_B1:    if (trace_ready_i) state_d = S_B2;
      S_B2:    if (trace_ready_i) state_d = (count_q != '0) ? S_B0 : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (head_take) head_d = fifo_q[rd_ptr_q];
  end

  // Beat payload is a pure function of state and the latched head, so it is
  // inherently stable while the consumer back-pressures.
  always_comb begin
    beat0                = '0;
    beat0[31:30]         = head_q.typ;
    beat0[STAMP_W-1:0]   = head_q.stamp;
    trace_data_o         = 32'd0;
    case (state_q)
      S_B0:    trace_data_o = beat0;
      S_B1:    trace_data_o = head_q.field;
      S_B2:    trace_data_o = head_q.data;
      default: trace_data_o = 32'd0;
    endcase
  end

  assign trace_valid_o = (state_q != S_IDLE);
  assign trace_last_o  = (state_q == S_B2);
  assign cycle_cnt_o   = cycle_cnt_q;
  assign stall_cnt_o   = stall_cnt_q;
  assign flush_cnt_o   = flush_cnt_q;
  assign drop_cnt_o    = drop_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      fifo_q      <= '{default: '0};
      head_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      fifo_q      <= fifo_d;
      head_q      <= head_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cycle_cnt_q <= cycle_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_trace_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_trace_unit
// Purpose  : Self-checking bench for cpu_trace_unit. A queue-based
//            reference model tracks records, drops and counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_trace_unit;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, stall = 1'b0, branch = 1'b0, flush = 1'b0;
  logic        wb_en = 1'b0, mem_wr = 1'b0, ready = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0, mem_addr = '0, mem_data = '0;
  logic        valid, last;
  logic [31:0] data, cycle_cnt, stall_cnt, flush_cnt, drop_cnt;

  always #5 clk = ~clk;

  cpu_trace_unit #(.FIFO_DEPTH(DEPTH), .STAMP_W(16), .CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall),
    .branch_i(branch), .flush_i(flush), .wb_en_i(wb_en), .wb_rd_i(wb_rd),
    .wb_data_i(wb_data), .mem_wr_i(mem_wr), .mem_addr_i(mem_addr),
    .mem_data_i(mem_data), .trace_valid_o(valid), .trace_ready_i(ready),
    .trace_data_o(data), .trace_last_o(last), .cycle_cnt_o(cycle_cnt),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt), .drop_cnt_o(drop_cnt)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  typedef struct {
    logic [1:0]  typ;
    logic [31:0] f1;
    logic [31:0] dat;
    logic [15:0] stamp;
  } rec_t;

  rec_t        q[$];
  rec_t        m_cur;
  bit          m_busy;
  int          m_beat;
  logic [31:0] m_cycle, m_stall, m_flush, m_drop;

  function automatic logic [31:0] inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [31:0] m_data();
    if (!m_busy) return 32'd0;
    case (m_beat)
      0:       return {m_cur.typ, 14'b0, m_cur.stamp};
      1:       return m_cur.f1;
      default: return m_cur.dat;
    endcase
  endfunction

  function automatic logic m_last();
    return m_busy && (m_beat == 2);
  endfunction

  task automatic model_reset();
    q.delete();
    m_busy = 0; m_beat = 0;
    m_cycle = 0; m_stall = 0; m_flush = 0; m_drop = 0;
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    rec_t e;
    int   sz   = q.size();
    int   room = DEPTH - sz;
    if (!m_busy) begin
      if (sz != 0) begin m_cur = q.pop_front(); m_busy = 1; m_beat = 0; end
    end else if (ready) begin
      if (m_beat < 2) m_beat++;
      else if (sz != 0) begin m_cur = q.pop_front(); m_beat = 0; end
      else m_busy = 0;
    end
    if (start) begin
      if (wb_en && wb_rd != 5'd0) begin
        e = '{2'b01, {27'b0, wb_rd}, wb_data, m_cycle[15:0]};
        if (room > 0) begin q.push_back(e); room--; end
        else m_drop = inc(m_drop);
      end
      if (mem_wr) begin
        e = '{2'b10, mem_addr, mem_data, m_cycle[15:0]};
        if (room > 0) begin q.push_back(e); room--; end
        else m_drop = inc(m_drop);
      end
      m_cycle = inc(m_cycle);
      if (stall && !branch) m_stall = inc(m_stall);
      if (flush) m_flush = inc(m_flush);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    stall = 0; branch = 0; flush = 0; wb_en = 0; mem_wr = 0;
    wb_rd = '0; wb_data = '0; mem_addr = '0; mem_data = '0;
  endtask

  task automatic do_reset();
    clear_events();
    start = 0; ready = 0; rst = 1;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_events();
    rst = 1;
    #2;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
    checks++; if (last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", last); end
    checks++; if (data !== 32'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", data); end
    checks++; if ({cycle_cnt, stall_cnt, flush_cnt, drop_cnt} !== 128'd0) begin
      errors++; $display("FAIL reset_counters: got %h %h %h %h expected all 0", cycle_cnt, stall_cnt, flush_cnt, drop_cnt);
    end
    do_reset();
  endtask

  task automatic test_cycle_count();
    do_reset();
    start = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL idle_valid: cycle %0d got %b expected 0", i, valid); end
    end
    checks++; if (cycle_cnt !== 32'd10) begin errors++; $display("FAIL cycle_cnt: got %0d expected 10", cycle_cnt); end
    checks++; if ({stall_cnt, flush_cnt, drop_cnt} !== 96'd0) begin
      errors++; $display("FAIL idle_counters: got %0d %0d %0d expected 0 0 0", stall_cnt, flush_cnt, drop_cnt);
    end
  endtask

  task automatic test_stall_flush();
    do_reset();
    start = 1; stall = 1;
    repeat (3) tick();
    branch = 1;
    repeat (2) tick();
    stall = 0; branch = 0; flush = 1;
    tick();
    flush = 0;
    checks++; if (stall_cnt !== 32'd3) begin errors++; $display("FAIL stall_cnt: got %0d expected 3", stall_cnt); end
    checks++; if (flush_cnt !== 32'd1) begin errors++; $display("FAIL flush_cnt: got %0d expected 1", flush_cnt); end
    checks++; if (cycle_cnt !== 32'd6) begin errors++; $display("FAIL stall_cycle_cnt: got %0d expected 6", cycle_cnt); end
  endtask

  task automatic test_single_record();
    logic [31:0] exp_b [3];
    int n = 0;
    exp_b[0] = 32'h4000_0005; exp_b[1] = 32'h0000_0003; exp_b[2] = 32'h0000_0012;
    do_reset();
    start = 1;
    repeat (5) tick();
    ready = 1; wb_en = 1; wb_rd = 5'd3; wb_data = 32'h12;
    tick();
    clear_events();
    while (!valid && n < 10) begin tick(); n++; end
    checks++; if (!valid) begin errors++; $display("FAIL single_timeout: valid never rose within 10 cycles"); end
    for (int b = 0; b < 3; b++) begin
      checks++; if (valid !== 1'b1 || data !== exp_b[b]) begin
        errors++; $display("FAIL single_beat%0d: got valid=%b data=%h expected valid=1 data=%h", b, valid, data, exp_b[b]);
      end
      checks++; if (last !== (b == 2)) begin errors++; $display("FAIL single_last%0d: got %b expected %b", b, last, (b == 2)); end
      tick();
    end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL single_after: got valid %b expected 0", valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] beats [$];
    int first = -1, lastc = -1;
    do_reset();
    start = 1; ready = 1;
    wb_en = 1; wb_rd = 5'd9; wb_data = 32'd7;
    mem_wr = 1; mem_addr = 32'h0C; mem_data = 32'd18;
    tick();
    mem_wr = 0; wb_rd = 5'd0; wb_data = 32'hDEAD_BEEF;   // x0 write: never traced
    tick();
    clear_events();
    for (int i = 0; i < 12; i++) begin
      checks++; if (valid !== m_busy || (valid && (data !== m_data() || last !== m_last()))) begin
        errors++; $display("FAIL b2b_beat: cycle %0d got v=%b d=%h l=%b expected v=%b d=%h l=%b", i, valid, data, last, m_busy, m_data(), m_last());
      end
      if (valid) begin
        if (first < 0) first = i;
        lastc = i;
        beats.push_back(data);
      end
      tick();
    end
    checks++; if (beats.size() != 6 || lastc - first != 5) begin
      errors++; $display("FAIL b2b_count: got %0d beats over span %0d expected 6 contiguous", beats.size(), lastc - first + 1);
    end
    if (beats.size() == 6) begin
      checks++; if (beats[0][31:30] !== 2'b01 || beats[1] !== 32'd9 || beats[2] !== 32'd7) begin
        errors++; $display("FAIL b2b_reg: got %h %h %h expected type 01, 9, 7", beats[0], beats[1], beats[2]);
      end
      checks++; if (beats[3][31:30] !== 2'b10 || beats[4] !== 32'h0C || beats[5] !== 32'd18) begin
        errors++; $display("FAIL b2b_mem: got %h %h %h expected type 10, c, 12", beats[3], beats[4], beats[5]);
      end
    end
  endtask

  task automatic test_overflow();
    int exp_recs, recs = 0, n = 0;
    do_reset();
    start = 1; ready = 0;
    for (int i = 0; i < 12; i++) begin
      clear_events();
      if (i % 2 == 0) begin
        wb_en = 1; wb_rd = 5'($urandom_range(31, 1)); wb_data = $urandom;
      end else begin
        mem_wr = 1; mem_addr = $urandom; mem_data = $urandom;
      end
      tick();
    end
    clear_events();
    // The first record already sits in the serializer's output register.
    checks++; if (drop_cnt !== m_drop) begin errors++; $display("FAIL ovf_drop: got %0d expected %0d", drop_cnt, m_drop); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL ovf_hold: got valid %b expected 1", valid); end
    exp_recs = q.size() + (m_busy ? 1 : 0);
    ready = 1;
    while (n < 60 && (m_busy || q.size() != 0)) begin
      checks++; if (valid !== m_busy || (valid && (data !== m_data() || last !== m_last()))) begin
        errors++; $display("FAIL ovf_beat: cycle %0d got v=%b d=%h l=%b expected v=%b d=%h l=%b", n, valid, data, last, m_busy, m_data(), m_last());
      end
      if (valid && last) recs++;
      tick(); n++;
    end
    checks++; if (recs != exp_recs || valid !== 1'b0) begin
      errors++; $display("FAIL ovf_drain: got %0d records (valid=%b) expected %0d then idle", recs, valid, exp_recs);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      start  = ($urandom_range(9, 0) != 0);
      stall  = $urandom_range(1, 0); branch = $urandom_range(1, 0); flush = $urandom_range(1, 0);
      wb_en  = ($urandom_range(2, 0) == 0); wb_rd = 5'($urandom); wb_data = $urandom;
      mem_wr = ($urandom_range(2, 0) == 0); mem_addr = $urandom; mem_data = $urandom;
      ready  = ($urandom_range(3, 0) != 0);
      tick();
      checks++; if (valid !== m_busy || (valid && (data !== m_data() || last !== m_last()))) begin
        errors++; $display("FAIL rand_stream: cycle %0d got v=%b d=%h l=%b expected v=%b d=%h l=%b", i, valid, data, last, m_busy, m_data(), m_last());
      end
      checks++; if (cycle_cnt !== m_cycle || stall_cnt !== m_stall || flush_cnt !== m_flush || drop_cnt !== m_drop) begin
        errors++; $display("FAIL rand_counters: cycle %0d got %0d %0d %0d %0d expected %0d %0d %0d %0d", i, cycle_cnt, stall_cnt, flush_cnt, drop_cnt, m_cycle, m_stall, m_flush, m_drop);
      end
    end
    clear_events();
  endtask

  task automatic test_reset_mid_record();
    do_reset();
    start = 1; ready = 0;
    for (int i = 0; i < 4; i++) begin
      wb_en = 1; wb_rd = 5'(i + 5); wb_data = 32'h100 + i;
      tick();
    end
    clear_events();
    ready = 1; tick();          // beat0 accepted, beat1 now pending
    ready = 0;
    checks++; if (valid !== 1'b1 || data !== 32'd5) begin
      errors++; $display("FAIL mid_setup: got valid=%b data=%h expected valid=1 data=5", valid, data);
    end
    #2 rst = 1;
    #1;
    checks++; if (valid !== 1'b0 || last !== 1'b0 || data !== 32'd0) begin
      errors++; $display("FAIL mid_reset_out: got v=%b d=%h l=%b expected 0 0 0", valid, data, last);
    end
    @(posedge clk); #1;
    checks++; if (valid !== 1'b0 || {cycle_cnt, stall_cnt, flush_cnt, drop_cnt} !== 128'd0) begin
      errors++; $display("FAIL mid_reset_next: got v=%b cnt=%0d %0d %0d %0d expected 0", valid, cycle_cnt, stall_cnt, flush_cnt, drop_cnt);
    end
    rst = 0; start = 0; ready = 1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL mid_fifo_empty: cycle %0d got valid %b expected 0", i, valid); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_cycle_count();
    test_stall_flush();
    test_single_record();
    test_back_to_back();
    test_overflow();
    test_random();
    test_reset_mid_record();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
